lcd_bus_sequencer: RTL and testbench

LCD_BUS_SEQUENCER -- requirements
Module: lcd_bus_sequencer

---
 rtl/lcd_pkg.sv | 41 ++++
 rtl/lcd_delay_counter.sv | 31 +++
 rtl/lcd_bus_sequencer.sv | 166 ++++++++++++++++
 tb/tb_lcd_bus_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD bus sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT_ISSUE,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_t;

  localparam int INIT_LEN = 7;

  // HD44780-style command codes
  localparam logic [7:0] CLR   = 8'h01;
  localparam logic [7:0] HOME  = 8'h02;
  localparam logic [7:0] FSET  = 8'h38;
  localparam logic [7:0] DON   = 8'h0C;
  localparam logic [7:0] EMODE = 8'h06;

  // Any command with no bits set outside the clear/home bits is a slow one.
  localparam logic [7:0] LONG_CMD_MASK = ~(CLR | HOME);

  // Init ROM, entry 0 first: FSET x4, DON, CLR, EMODE.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM =
    {EMODE, CLR, DON, FSET, FSET, FSET, FSET};

  // Clear/home style commands need the long settle time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] dat);
    return !rs && ((dat & LONG_CMD_MASK) == 8'h00);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter timing every sequencer delay; done while count is 1.
// Latency: a load of N makes done assert N cycles after the load edge.
// Backpressure: none; start overrides any count in progress.
module lcd_delay_counter #(
  parameter int CNT_W = 8
) (
  input  logic             fpga_clk_i,
  input  logic             fpga_reset_i,
  input  logic             start,
  input  logic [CNT_W-1:0] load_val,
  output logic             done,
  output logic             idle
);

  logic [CNT_W-1:0] cnt;

  // Load on start, otherwise count down and park at zero.
  always_ff @(posedge fpga_clk_i or posedge fpga_reset_i) begin
    if (fpga_reset_i) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == CNT_W'(1));
  assign idle = (cnt == '0);

endmodule

// File: rtl/lcd_bus_sequencer.sv
// Sequences power-up, the LCD init ROM, then requester bytes onto the LCD bus.
// Latency: accept at edge k -> E high k+1..k+EN, ready again 1+EN+1+wait cycles later.
// Backpressure: cmd_ready_o only in IDLE after init; valid is ignored otherwise.
module lcd_bus_sequencer
  import lcd_pkg::*;
#(
  parameter int EN_PULSE_CYC   = 25,
  parameter int SHORT_WAIT_CYC = 2500,
  parameter int LONG_WAIT_CYC  = 82000,
  parameter int PWRUP_WAIT_CYC = 2000000
) (
  input  logic       fpga_clk_i,
  input  logic       fpga_reset_i,
  input  logic       cmd_valid_i,
  input  logic       cmd_rs_i,
  input  logic [7:0] cmd_data_i,
  output logic       cmd_ready_o,
  output logic       busy_o,
  output logic       init_done_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_enable_o,
  output logic       lcd_reset_o
);

  localparam int MAX_CYC = max_int(max_int(EN_PULSE_CYC, SHORT_WAIT_CYC),
                                   max_int(LONG_WAIT_CYC, PWRUP_WAIT_CYC));
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  lcd_state_t       state, state_nxt;
  logic [2:0]       init_idx;
  logic             cnt_start;
  logic [CNT_W-1:0] cnt_load;
  logic             cnt_done;
  logic             cnt_idle;
  logic             dat_ld;
  logic [7:0]       dat_nxt;
  logic             rs_nxt;
  logic             idx_inc;
  logic             done_set;

  lcd_delay_counter #(
    .CNT_W (CNT_W)
  ) u_delay (
    .fpga_clk_i   (fpga_clk_i),
    .fpga_reset_i (fpga_reset_i),
    .start        (cnt_start),
    .load_val     (cnt_load),
    .done         (cnt_done),
    .idle         (cnt_idle)
  );

  // State register; reset parks in PWRUP so the whole bring-up replays.
  always_ff @(posedge fpga_clk_i or posedge fpga_reset_i) begin
    if (fpga_reset_i) begin
      state <= ST_PWRUP;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, counter loads, bus loads and state-decoded outputs.
  always_comb begin
    state_nxt    = state;
    cnt_start    = 1'b0;
    cnt_load     = '0;
    dat_ld       = 1'b0;
    dat_nxt      = lcd_data_o;
    rs_nxt       = lcd_rs_o;
    idx_inc      = 1'b0;
    done_set     = 1'b0;
    cmd_ready_o  = 1'b0;
    busy_o       = 1'b1;
    lcd_enable_o = 1'b0;
    lcd_reset_o  = 1'b0;

    case (state)
      ST_PWRUP: begin
        lcd_reset_o = 1'b1;
        // The first PWRUP cycle arms the counter, so load one less.
        if (cnt_idle) begin
          cnt_start = 1'b1;
          cnt_load  = CNT_W'(PWRUP_WAIT_CYC - 1);
        end else if (cnt_done) begin
          state_nxt = ST_INIT_ISSUE;
        end
      end
      ST_INIT_ISSUE: begin
        dat_ld    = 1'b1;
        dat_nxt   = INIT_ROM[init_idx];
        rs_nxt    = 1'b0;
        state_nxt = ST_SETUP;
      end
      ST_IDLE: begin
        busy_o      = 1'b0;
        cmd_ready_o = init_done_o;
        if (cmd_valid_i && init_done_o) begin
          dat_ld    = 1'b1;
          dat_nxt   = cmd_data_i;
          rs_nxt    = cmd_rs_i;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_start = 1'b1;
        cnt_load  = CNT_W'(EN_PULSE_CYC);
        state_nxt = ST_PULSE;
      end
      ST_PULSE: begin
        lcd_enable_o = 1'b1;
        if (cnt_done) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        cnt_start = 1'b1;
        cnt_load  = is_long_cmd(lcd_rs_o, lcd_data_o) ? CNT_W'(LONG_WAIT_CYC)
                                                      : CNT_W'(SHORT_WAIT_CYC);
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_done) begin
          if (init_done_o) begin
            state_nxt = ST_IDLE;
          end else if (init_idx < 3'(INIT_LEN - 1)) begin
            idx_inc   = 1'b1;
            state_nxt = ST_INIT_ISSUE;
          end else begin
            done_set  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_PWRUP;
      end
    endcase
  end

  // Bus registers: loaded only when a byte is launched, held otherwise.
  always_ff @(posedge fpga_clk_i or posedge fpga_reset_i) begin
    if (fpga_reset_i) begin
      lcd_data_o <= 8'h00;
      lcd_rs_o   <= 1'b0;
    end else if (dat_ld) begin
      lcd_data_o <= dat_nxt;
      lcd_rs_o   <= rs_nxt;
    end
  end

  // Init ROM pointer and sticky init-complete flag.
  always_ff @(posedge fpga_clk_i or posedge fpga_reset_i) begin
    if (fpga_reset_i) begin
      init_idx    <= 3'd0;
      init_done_o <= 1'b0;
    end else begin
      if (idx_inc) begin
        init_idx <= init_idx + 3'd1;
      end
      if (done_set) begin
        init_done_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Directed bench for lcd_bus_sequencer with shortened timing parameters.
// Latency: checks E window and ready return against hand-computed cycle counts.
// Backpressure: holds valid across init and back-to-back bytes.
module tb_lcd_bus_sequencer;

  localparam int EN    = 4;
  localparam int SHORT = 10;
  localparam int LONG  = 40;
  localparam int PWRUP = 100;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready_o;
  logic       busy_o;
  logic       init_done_o;
  logic [7:0] lcd_data_o;
  logic       lcd_rs_o;
  logic       lcd_enable_o;
  logic       lcd_reset_o;

  int n_vec;
  int n_bad;
  int ready_early;

  typedef struct {
    logic       rs;
    logic [7:0] dat;
    int         lat;
  } vec_t;

  vec_t       vecs [10];
  logic [7:0] rom_exp [7];
  int         gap_exp [7];

  lcd_bus_sequencer #(
    .EN_PULSE_CYC   (EN),
    .SHORT_WAIT_CYC (SHORT),
    .LONG_WAIT_CYC  (LONG),
    .PWRUP_WAIT_CYC (PWRUP)
  ) dut (
    .fpga_clk_i   (clk),
    .fpga_reset_i (rst),
    .cmd_valid_i  (cmd_valid),
    .cmd_rs_i     (cmd_rs),
    .cmd_data_i   (cmd_data),
    .cmd_ready_o  (cmd_ready_o),
    .busy_o       (busy_o),
    .init_done_o  (init_done_o),
    .lcd_data_o   (lcd_data_o),
    .lcd_rs_o     (lcd_rs_o),
    .lcd_enable_o (lcd_enable_o),
    .lcd_reset_o  (lcd_reset_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},  {31'd0, cmd_ready_o},  32'd0);
    check({tag, "_busy"},   {31'd0, busy_o},       32'd1);
    check({tag, "_idone"},  {31'd0, init_done_o},  32'd0);
    check({tag, "_data"},   {24'd0, lcd_data_o},   32'h00);
    check({tag, "_rs"},     {31'd0, lcd_rs_o},     32'd0);
    check({tag, "_en"},     {31'd0, lcd_enable_o}, 32'd0);
    check({tag, "_lcdrst"}, {31'd0, lcd_reset_o},  32'd1);
  endtask

  task automatic step();
    @(negedge clk);
    if (cmd_ready_o === 1'b1 && init_done_o !== 1'b1) ready_early++;
  endtask

  // Called one time unit after reset release; returns on the first sample with init_done high.
  task automatic check_init();
    int         hi;
    int         lo;
    int         eh;
    int         dbad;
    logic [7:0] d;
    logic       r;
    ready_early = 0;
    hi = 0;
    while (lcd_reset_o === 1'b1 && hi < 1000) begin
      hi++;
      step();
    end
    check("pwrup_len", hi, PWRUP);
    for (int j = 0; j < 7; j++) begin
      lo = 0;
      while (lcd_enable_o !== 1'b1 && lo < 1000) begin
        lo++;
        step();
      end
      check($sformatf("init_gap_before_%0d", j), lo, (j == 0) ? 2 : gap_exp[j-1]);
      d    = lcd_data_o;
      r    = lcd_rs_o;
      eh   = 0;
      dbad = 0;
      while (lcd_enable_o === 1'b1 && eh < 1000) begin
        eh++;
        if (lcd_data_o !== d || lcd_rs_o !== r) dbad++;
        step();
      end
      check($sformatf("init_data_%0d", j), {24'd0, d}, {24'd0, rom_exp[j]});
      check($sformatf("init_rs_%0d", j), {31'd0, r}, 32'd0);
      check($sformatf("init_en_len_%0d", j), eh, EN);
      check($sformatf("init_hold_%0d", j), dbad, 0);
    end
    lo = 0;
    while (init_done_o !== 1'b1 && lo < 1000) begin
      lo++;
      step();
    end
    check("init_final_wait", lo, gap_exp[6]);
    check("init_ready_early", ready_early, 0);
    check("init_ready_after", {31'd0, cmd_ready_o}, 32'd1);
    check("init_lcdrst_low", {31'd0, lcd_reset_o}, 32'd0);
  endtask

  // Starts on the sample right after the accepting edge (SETUP), ends when ready returns.
  task automatic measure(input string tag, input logic [7:0] xd, input logic xr, input int xlat);
    int   t;
    int   e_bad;
    int   d_bad;
    logic e_exp;
    t     = 0;
    e_bad = 0;
    d_bad = 0;
    check({tag, "_setup_data"}, {24'd0, lcd_data_o}, {24'd0, xd});
    check({tag, "_setup_rs"}, {31'd0, lcd_rs_o}, {31'd0, xr});
    while (cmd_ready_o !== 1'b1 && t < 500) begin
      e_exp = (t >= 1 && t <= EN);
      if (lcd_enable_o !== e_exp) e_bad++;
      if (lcd_data_o !== xd || lcd_rs_o !== xr) d_bad++;
      @(negedge clk);
      t++;
    end
    check({tag, "_en_window"}, e_bad, 0);
    check({tag, "_data_hold"}, d_bad, 0);
    check({tag, "_ready_lat"}, t, xlat);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (cmd_ready_o !== 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("ready_timeout", {31'd0, cmd_ready_o}, 32'd1);
  endtask

  initial begin
    int rises;
    logic e_prev;
    n_vec = 0;
    n_bad = 0;
    ready_early = 0;

    rom_exp = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    // Low E cycles after each init entry: HOLD + WAIT + INIT_ISSUE + SETUP,
    // last one is HOLD + WAIT until init_done.
    gap_exp = '{13, 13, 13, 13, 13, 43, 11};
    // Ready latency: 1 + EN + 1 + wait -> 16 short, 46 long.
    vecs[0] = '{rs: 1'b1, dat: 8'h41, lat: 16};
    vecs[1] = '{rs: 1'b0, dat: 8'h01, lat: 46};
    vecs[2] = '{rs: 1'b0, dat: 8'h04, lat: 16};
    vecs[3] = '{rs: 1'b0, dat: 8'h02, lat: 46};
    vecs[4] = '{rs: 1'b0, dat: 8'h03, lat: 46};
    vecs[5] = '{rs: 1'b1, dat: 8'h01, lat: 16};
    vecs[6] = '{rs: 1'b0, dat: 8'h00, lat: 46};
    vecs[7] = '{rs: 1'b1, dat: 8'h00, lat: 16};
    vecs[8] = '{rs: 1'b0, dat: 8'h0C, lat: 16};
    vecs[9] = '{rs: 1'b0, dat: 8'h80, lat: 16};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_rs    = 1'b0;
    cmd_data  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst");

    // Valid held high across the whole bring-up must be ignored.
    cmd_valid = 1'b1;
    cmd_rs    = 1'b1;
    cmd_data  = 8'h41;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_init();

    // 0x41 accepted on the first ready edge, 0x42 queued right behind it.
    @(posedge clk);
    @(negedge clk);
    cmd_data = 8'h42;
    measure("b2b_first", 8'h41, 1'b1, 16);
    @(negedge clk);
    check("b2b_second_accept", {24'd0, lcd_data_o}, 32'h42);
    check("b2b_second_busy", {31'd0, busy_o}, 32'd1);
    cmd_valid = 1'b0;
    measure("b2b_second", 8'h42, 1'b1, 16);
    rises  = 0;
    e_prev = lcd_enable_o;
    repeat (30) begin
      @(negedge clk);
      if (lcd_enable_o === 1'b1 && e_prev !== 1'b1) rises++;
      e_prev = lcd_enable_o;
    end
    check("b2b_no_dup", rises, 0);
    check("idle_busy", {31'd0, busy_o}, 32'd0);

    for (int v = 0; v < 10; v++) begin
      wait_ready();
      cmd_rs    = vecs[v].rs;
      cmd_data  = vecs[v].dat;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      measure($sformatf("vec%0d", v), vecs[v].dat, vecs[v].rs, vecs[v].lat);
      check($sformatf("vec%0d_idle_hold", v), {24'd0, lcd_data_o}, {24'd0, vecs[v].dat});
    end

    // Reset in the third PULSE cycle.
    wait_ready();
    cmd_rs    = 1'b1;
    cmd_data  = 8'h55;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midpulse_en_before", {31'd0, lcd_enable_o}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midpulse");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_init();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
